// File: rtl/pulse_arb.sv
// Round-robin arbiter that funnels four single-cycle request streams into one
// pulse-synchronizer channel, with completion timeout, inter-transaction gap and overflow flags.
module pulse_arb #(
    parameter int GAP = 3,
    parameter int TMO = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_in,
    output logic       chan_pulse,
    output logic [1:0] chan_id,
    input  logic       chan_done,
    output logic [3:0] grant_ack,
    output logic       tmo_err,
    output logic [3:0] ovf,
    input  logic       ovf_clr,
    output logic       idle
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

    state_t     state, state_d;
    logic [3:0] pending, pending_d;
    logic [3:0] pend_clr;
    logic [3:0] ovf_set, ovf_d;
    logic [1:0] cur_id, cur_id_d;
    logic [1:0] last_served, last_served_d;
    logic [7:0] cnt, cnt_d;

    logic       chan_pulse_d;
    logic [1:0] chan_id_d;
    logic [3:0] grant_ack_d;
    logic       tmo_err_d;

    logic       rr_found;
    logic [1:0] rr_pick;

    // Search starts one past the last winner, so every requester gets a turn.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            if (!rr_found && pending[2'(last_served + 2'(k))]) begin
                rr_found = 1'b1;
                rr_pick  = 2'(last_served + 2'(k));
            end
        end
    end

    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        cur_id_d      = cur_id;
        last_served_d = last_served;
        chan_pulse_d  = 1'b0;
        chan_id_d     = 2'd0;
        grant_ack_d   = 4'b0000;
        tmo_err_d     = 1'b0;
        pend_clr      = 4'b0000;

        case (state)
            S_IDLE: begin
                if (rr_found) begin
                    cur_id_d      = rr_pick;
                    last_served_d = rr_pick;
                    chan_pulse_d  = 1'b1;
                    chan_id_d     = rr_pick;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                pend_clr = 4'b0001 << cur_id;
                cnt_d    = 8'd0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // A completion arriving on the last allowed cycle still wins.
                if (chan_done) begin
                    grant_ack_d = 4'b0001 << cur_id;
                    cnt_d       = 8'd0;
                    state_d     = S_GAP;
                end else if (cnt == TMO_LAST) begin
                    tmo_err_d = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = S_GAP;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A request landing on the cycle its bit is retired re-arms it cleanly.
    always_comb begin
        ovf_set   = req_in & pending & ~pend_clr;
        pending_d = (pending & ~pend_clr) | req_in;
        ovf_d     = (ovf_clr ? 4'b0000 : ovf) | ovf_set;
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pending     <= 4'b0000;
            ovf         <= 4'b0000;
            cur_id      <= 2'd0;
            last_served <= 2'd3;
            cnt         <= 8'd0;
            chan_pulse  <= 1'b0;
            chan_id     <= 2'd0;
            grant_ack   <= 4'b0000;
            tmo_err     <= 1'b0;
        end else begin
            state       <= state_d;
            pending     <= pending_d;
            ovf         <= ovf_d;
            cur_id      <= cur_id_d;
            last_served <= last_served_d;
            cnt         <= cnt_d;
            chan_pulse  <= chan_pulse_d;
            chan_id     <= chan_id_d;
            grant_ack   <= grant_ack_d;
            tmo_err     <= tmo_err_d;
        end
    end

    assign idle = (state == S_IDLE) && (pending == 4'b0000);

endmodule

// File: tb/tb_pulse_arb.sv
// Scoreboard bench for pulse_arb: a transaction-timeline model predicts every
// launch, ack and timeout; a monitor pops and compares as the DUT emits them.
module tb_pulse_arb;

    localparam int GAP  = 3;
    localparam int TMO  = 16;
    localparam int NDLY = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_in;
    logic       chan_pulse;
    logic [1:0] chan_id;
    logic       chan_done;
    logic [3:0] grant_ack;
    logic       tmo_err;
    logic [3:0] ovf;
    logic       ovf_clr;
    logic       idle;

    pulse_arb #(.GAP(GAP), .TMO(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .chan_pulse(chan_pulse),
        .chan_id   (chan_id),
        .chan_done (chan_done),
        .grant_ack (grant_ack),
        .tmo_err   (tmo_err),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_PULSE = 0, EV_GRANT = 1, EV_TMO = 2} ev_kind_t;
    typedef struct {
        int       cyc;
        ev_kind_t kind;
        int       val;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    // Channel completion delay per transaction (0 = never returns); shared by
    // the model and the responder, each walking it with its own index.
    int dly[NDLY];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0] m_pend = 4'b0, m_ovf = 4'b0;
    int         m_last = 3, m_idle_from = 0, m_clr_cyc = -1, m_clr_id = 0, mk = 0;
    logic [3:0] exp_ovf = 4'b0;
    logic       exp_idle = 1'b1;

    task automatic model_cycle(input logic [3:0] r_in, input logic clr, input logic r);
        int c, id, d, t, e;
        logic [3:0] clr_mask;
        ev_t ev;
        c        = cyc;
        exp_ovf  = m_ovf;
        exp_idle = (c >= m_idle_from) && (m_pend == 4'b0);
        if (r) begin
            exp_q.delete();
            m_pend = 4'b0; m_ovf = 4'b0; m_last = 3;
            m_idle_from = c + 1; m_clr_cyc = -1;
            return;
        end
        if (c >= m_idle_from && m_pend != 4'b0) begin
            id = -1;
            for (int k = 1; k <= 4; k++)
                if (id < 0 && m_pend[(m_last + k) % 4]) id = (m_last + k) % 4;
            m_last = id;
            t = c + 1;
            d = dly[mk];
            mk++;
            ev.cyc = t; ev.kind = EV_PULSE; ev.val = id;
            exp_q.push_back(ev);
            if (d >= 1 && d <= TMO) begin
                e = t + d + 1;
                ev.cyc = e; ev.kind = EV_GRANT; ev.val = 1 << id;
            end else begin
                e = t + TMO + 1;
                ev.cyc = e; ev.kind = EV_TMO; ev.val = 1;
            end
            exp_q.push_back(ev);
            m_idle_from = e + GAP;
            m_clr_cyc   = t;
            m_clr_id    = id;
        end
        clr_mask = (c == m_clr_cyc) ? 4'(1 << m_clr_id) : 4'b0;
        m_ovf    = (clr ? 4'b0 : m_ovf) | (r_in & m_pend & ~clr_mask);
        m_pend   = (m_pend & ~clr_mask) | r_in;
    endtask

    // ---------------- monitor ----------------
    bit mon_en = 1'b0;
    int last_pulse_cyc = -1, last_pulse_id = -1;
    int last_grant_cyc = -1, last_grant_val = -1, last_tmo_cyc = -1;
    int n_pulse = 0, n_grant = 0, n_tmo = 0;
    int pulse_log[$];

    task automatic match(input ev_kind_t k, input int v);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: kind %0d value %0d, none expected (cycle %0d)", k, v, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", k, e.kind);
            check("event_cycle", cyc, e.cyc);
            check("event_value", v, e.val);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL missing_event: kind %0d value %0d due cycle %0d, not seen",
                         exp_q[0].kind, exp_q[0].val, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (chan_pulse === 1'b1) begin
                match(EV_PULSE, int'(chan_id));
                n_pulse++;
                last_pulse_cyc = cyc;
                last_pulse_id  = int'(chan_id);
                pulse_log.push_back(int'(chan_id));
            end else begin
                check("chan_id_when_no_pulse", chan_id, 0);
            end
            if (grant_ack !== 4'b0) begin
                match(EV_GRANT, int'(grant_ack));
                n_grant++;
                last_grant_cyc = cyc;
                last_grant_val = int'(grant_ack);
            end
            if (tmo_err !== 1'b0) begin
                match(EV_TMO, int'(tmo_err));
                n_tmo++;
                last_tmo_cyc = cyc;
            end
            check("ovf", ovf, exp_ovf);
            check("idle", idle, exp_idle);
        end
    end

    // ---------------- channel responder ----------------
    int done_at = -1;
    int rk = 0;

    always @(negedge clk) begin
        if (mon_en && chan_pulse === 1'b1) begin
            done_at = (dly[rk] > 0) ? cyc + dly[rk] : -1;
            rk++;
        end
    end

    initial begin
        chan_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            chan_done = (done_at == cyc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic [3:0] r_in, input logic clr, input logic r);
        req_in  = r_in;
        ovf_clr = clr;
        rst     = r;
        model_cycle(r_in, clr, r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(4'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_chan_pulse"}, chan_pulse, 0);
        check({tag, "_chan_id"}, chan_id, 0);
        check({tag, "_grant_ack"}, grant_ack, 0);
        check({tag, "_tmo_err"}, tmo_err, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_idle"}, idle, 1);
    endtask

    initial begin
        int b, g0, t0, n_id1;
        int fixed_dly[11] = '{3, 2, 2, 2, 2, 0, 2, 8, 2, 16, 19};
        for (int i = 0; i < NDLY; i++)
            dly[i] = (i < 11) ? fixed_dly[i] : int'($urandom_range(0, TMO + 4));

        req_in = 4'b0; ovf_clr = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) tick(4'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        check_reset_outputs("reset");

        // Single request, completion three cycles after launch.
        b = cyc;
        tick(4'b0001, 1'b0, 1'b0);
        idle_ticks(9);
        check("t1_idle_at_10", idle, 1);
        check("t1_pulse_cycle", last_pulse_cyc - b, 2);
        check("t1_pulse_id", last_pulse_id, 0);
        check("t1_grant_cycle", last_grant_cyc - b, 6);
        check("t1_grant_val", last_grant_val, 4'b0001);

        // All four at once from reset: served 0,1,2,3.
        tick(4'b0, 1'b0, 1'b1);
        pulse_log.delete();
        g0 = n_grant;
        tick(4'b1111, 1'b0, 1'b0);
        idle_ticks(34);
        check("t2_num_pulses", pulse_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check("t2_order", (i < pulse_log.size()) ? pulse_log[i] : -1, i);
        check("t2_num_grants", n_grant - g0, 4);
        check("t2_ovf", ovf, 0);

        // Channel never answers: timeout, then next launch only after the gap.
        tick(4'b0, 1'b0, 1'b1);
        b = cyc; g0 = n_grant; t0 = n_tmo;
        tick(4'b0100, 1'b0, 1'b0);
        idle_ticks(4);
        tick(4'b0001, 1'b0, 1'b0);
        idle_ticks(14);
        check("t3_pulse_cycle", last_pulse_cyc - b, 2);
        check("t3_pulse_id", last_pulse_id, 2);
        check("t3_tmo_cycle", last_tmo_cyc - b, 19);
        check("t3_tmo_count", n_tmo - t0, 1);
        check("t3_no_grant", n_grant - g0, 0);
        idle_ticks(10);
        check("t3_next_pulse_cycle", last_pulse_cyc - b, 23);
        check("t3_next_pulse_id", last_pulse_id, 0);

        // Requester 1 re-pulses while still pending: merged, overflow flagged.
        tick(4'b0, 1'b0, 1'b1);
        b = cyc;
        pulse_log.delete();
        tick(4'b0001, 1'b0, 1'b0);
        idle_ticks(3);
        tick(4'b0010, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);
        tick(4'b0010, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);
        tick(4'b0010, 1'b0, 1'b0);
        idle_ticks(11);
        check("t4_ovf_set", ovf, 4'b0010);
        tick(4'b0000, 1'b1, 1'b0);
        check("t4_ovf_cleared", ovf, 4'b0000);
        idle_ticks(9);
        n_id1 = 0;
        foreach (pulse_log[i]) if (pulse_log[i] == 1) n_id1++;
        check("t4_single_pulse_id1", n_id1, 1);
        check("t4_total_pulses", pulse_log.size(), 2);

        // Completion on the very cycle the timeout would fire.
        tick(4'b0, 1'b0, 1'b1);
        b = cyc; g0 = n_grant; t0 = n_tmo;
        tick(4'b0100, 1'b0, 1'b0);
        idle_ticks(24);
        check("t5_grant_cycle", last_grant_cyc - b, 19);
        check("t5_grant_val", last_grant_val, 4'b0100);
        check("t5_no_tmo", n_tmo - t0, 0);

        // Reset during WAIT; the late completion must be ignored.
        tick(4'b0, 1'b0, 1'b1);
        b = cyc; g0 = n_grant; t0 = n_tmo;
        tick(4'b1000, 1'b0, 1'b0);
        idle_ticks(4);
        tick(4'b0, 1'b0, 1'b1);
        check_reset_outputs("t6");
        idle_ticks(24);
        check("t6_no_grant", n_grant - g0, 0);
        check("t6_no_tmo", n_tmo - t0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            logic [3:0] r;
            r = 4'b0;
            for (int j = 0; j < 4; j++)
                if ($urandom_range(0, 9) == 0) r[j] = 1'b1;
            tick(r, 1'($urandom_range(0, 15) == 0), 1'b0);
        end
        idle_ticks(150);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_idle", idle, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
